// File: rtl/bcd_range_counter.sv
// Two-digit BCD counter over an inclusive range [MIN_VAL, upper bound] with tick counting,
// manual up/down adjust, checked parallel load and zero-latency carry/borrow for cascading.
module bcd_range_counter #(
  parameter int MIN_VAL     = 0,
  parameter int MAX_VAL     = 59,
  parameter int USE_DYN_MAX = 0,
  parameter int ADJ_CARRY   = 0,
  parameter int DIGIT_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   up_i,
  input  logic                   down_i,
  input  logic                   load_i,
  input  logic [DIGIT_W-1:0]     load_ten_i,
  input  logic [DIGIT_W-1:0]     load_unit_i,
  input  logic [2*DIGIT_W-1:0]   dyn_max_i,
  output logic [DIGIT_W-1:0]     ten_o,
  output logic [DIGIT_W-1:0]     unit_o,
  output logic                   carry_o,
  output logic                   borrow_o,
  output logic                   at_max_o,
  output logic                   err_o
);

  localparam logic [6:0] MIN_BIN   = 7'(MIN_VAL);
  localparam logic [3:0] MIN_TEN   = 4'(MIN_VAL / 10);
  localparam logic [3:0] MIN_UNIT  = 4'(MIN_VAL % 10);
  localparam logic [3:0] MAX_TEN   = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_UNIT  = 4'(MAX_VAL % 10);
  localparam logic       DYN_B     = (USE_DYN_MAX != 0);
  localparam logic       ADJ_B     = (ADJ_CARRY != 0);
  localparam logic       AT_MAX_RST = (MIN_VAL >= MAX_VAL);

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(4'd9);
  endfunction

  function automatic logic [6:0] to_bin(input logic [3:0] t, input logic [3:0] u);
    return 7'(t) * 7'd10 + 7'(u);
  endfunction

  logic [3:0] ten_r, unit_r;
  logic       at_max_r, err_r;
  logic [3:0] next_ten_s, next_unit_s;
  logic       next_err_s;
  logic [3:0] emax_ten_s, emax_unit_s;
  logic [6:0] emax_bin_s, v_bin_s, load_bin_s, next_bin_s;
  logic       dyn_ok_s, load_ok_s, inc_s, dec_s;

  assign v_bin_s    = to_bin(ten_r, unit_r);
  assign load_bin_s = to_bin(load_ten_i[3:0], load_unit_i[3:0]);
  assign dyn_ok_s   = digit_ok(dyn_max_i[2*DIGIT_W-1:DIGIT_W]) && digit_ok(dyn_max_i[DIGIT_W-1:0]) &&
                      (to_bin(dyn_max_i[DIGIT_W+3:DIGIT_W], dyn_max_i[3:0]) > MIN_BIN);
  assign load_ok_s  = digit_ok(load_ten_i) && digit_ok(load_unit_i) &&
                      (load_bin_s >= MIN_BIN) && (load_bin_s <= emax_bin_s);
  assign inc_s      = en_i | (up_i & ~down_i);
  assign dec_s      = down_i & ~up_i & ~en_i;
  assign emax_bin_s = to_bin(emax_ten_s, emax_unit_s);
  assign next_bin_s = to_bin(next_ten_s, next_unit_s);

  // Effective upper bound: an out-of-range run-time bound falls back to the static one
  always_comb begin
    emax_ten_s  = MAX_TEN;
    emax_unit_s = MAX_UNIT;
    if (DYN_B && dyn_ok_s) begin
      emax_ten_s  = dyn_max_i[DIGIT_W+3:DIGIT_W];
      emax_unit_s = dyn_max_i[3:0];
    end else begin
      emax_ten_s  = MAX_TEN;
      emax_unit_s = MAX_UNIT;
    end
  end

  // Next value by priority load > tick > adjust > hold
  always_comb begin
    next_ten_s  = ten_r;
    next_unit_s = unit_r;
    next_err_s  = 1'b0;
    if (load_i) begin
      if (load_ok_s) begin
        next_ten_s  = load_ten_i[3:0];
        next_unit_s = load_unit_i[3:0];
      end else begin
        next_err_s = 1'b1;
      end
    end else if (inc_s) begin
      // A value held above a shrunken bound also wraps here rather than being clamped
      if (v_bin_s >= emax_bin_s) begin
        next_ten_s  = MIN_TEN;
        next_unit_s = MIN_UNIT;
      end else if (unit_r == 4'd9) begin
        next_ten_s  = ten_r + 4'd1;
        next_unit_s = 4'd0;
      end else begin
        next_unit_s = unit_r + 4'd1;
      end
    end else if (dec_s) begin
      if (v_bin_s <= MIN_BIN) begin
        next_ten_s  = emax_ten_s;
        next_unit_s = emax_unit_s;
      end else if (unit_r == 4'd0) begin
        next_ten_s  = ten_r - 4'd1;
        next_unit_s = 4'd9;
      end else begin
        next_unit_s = unit_r - 4'd1;
      end
    end else begin
      next_ten_s  = ten_r;
      next_unit_s = unit_r;
    end
  end

  // State and registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ten_r    <= MIN_TEN;
      unit_r   <= MIN_UNIT;
      at_max_r <= AT_MAX_RST;
      err_r    <= 1'b0;
    end else begin
      ten_r    <= next_ten_s;
      unit_r   <= next_unit_s;
      at_max_r <= (next_bin_s >= emax_bin_s);
      err_r    <= next_err_s;
    end
  end

  assign ten_o    = DIGIT_W'(ten_r);
  assign unit_o   = DIGIT_W'(unit_r);
  assign at_max_o = at_max_r;
  assign err_o    = err_r;
  assign carry_o  = at_max_r & (en_i | (ADJ_B & up_i & ~down_i)) & ~load_i;
  assign borrow_o = ADJ_B & (v_bin_s == MIN_BIN) & down_i & ~up_i & ~en_i & ~load_i;

endmodule

// File: tb/tb_bcd_range_counter.sv
// Scoreboard bench for bcd_range_counter: four parameterisations share one stimulus bus; the
// driver queues hand-computed expectations and a negedge monitor compares the selected instance.
module tb_bcd_range_counter;

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] LD   = 4'b1000;
  localparam logic [3:0] EN   = 4'b0100;
  localparam logic [3:0] UP   = 4'b0010;
  localparam logic [3:0] DN   = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_i = 1'b0, up_i = 1'b0, down_i = 1'b0, load_i = 1'b0;
  logic [3:0] load_ten_i = 4'd0, load_unit_i = 4'd0;
  logic [7:0] dyn_max_i = 8'h00;

  logic [3:0] ten_w [4];
  logic [3:0] unit_w [4];
  logic       carry_w [4];
  logic       borrow_w [4];
  logic       at_max_w [4];
  logic       err_w [4];

  typedef struct {
    int         id;
    logic [7:0] v;
    logic       c, b, am, er;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_range_counter #(.MIN_VAL(0), .MAX_VAL(59), .USE_DYN_MAX(0), .ADJ_CARRY(0), .DIGIT_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .up_i(up_i), .down_i(down_i), .load_i(load_i),
    .load_ten_i(load_ten_i), .load_unit_i(load_unit_i), .dyn_max_i(dyn_max_i),
    .ten_o(ten_w[0]), .unit_o(unit_w[0]), .carry_o(carry_w[0]), .borrow_o(borrow_w[0]),
    .at_max_o(at_max_w[0]), .err_o(err_w[0]));

  bcd_range_counter #(.MIN_VAL(1), .MAX_VAL(59), .USE_DYN_MAX(1), .ADJ_CARRY(0), .DIGIT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .up_i(up_i), .down_i(down_i), .load_i(load_i),
    .load_ten_i(load_ten_i), .load_unit_i(load_unit_i), .dyn_max_i(dyn_max_i),
    .ten_o(ten_w[1]), .unit_o(unit_w[1]), .carry_o(carry_w[1]), .borrow_o(borrow_w[1]),
    .at_max_o(at_max_w[1]), .err_o(err_w[1]));

  bcd_range_counter #(.MIN_VAL(0), .MAX_VAL(23), .USE_DYN_MAX(0), .ADJ_CARRY(1), .DIGIT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .up_i(up_i), .down_i(down_i), .load_i(load_i),
    .load_ten_i(load_ten_i), .load_unit_i(load_unit_i), .dyn_max_i(dyn_max_i),
    .ten_o(ten_w[2]), .unit_o(unit_w[2]), .carry_o(carry_w[2]), .borrow_o(borrow_w[2]),
    .at_max_o(at_max_w[2]), .err_o(err_w[2]));

  bcd_range_counter #(.MIN_VAL(0), .MAX_VAL(23), .USE_DYN_MAX(0), .ADJ_CARRY(0), .DIGIT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .up_i(up_i), .down_i(down_i), .load_i(load_i),
    .load_ten_i(load_ten_i), .load_unit_i(load_unit_i), .dyn_max_i(dyn_max_i),
    .ten_o(ten_w[3]), .unit_o(unit_w[3]), .carry_o(carry_w[3]), .borrow_o(borrow_w[3]),
    .at_max_o(at_max_w[3]), .err_o(err_w[3]));

  task automatic check_field(input string nm, input string f, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h at %0t", nm, f, act, req, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare against the oldest queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check_field(mon_e.nm, "value",  {ten_w[mon_e.id], unit_w[mon_e.id]}, mon_e.v);
      check_field(mon_e.nm, "carry",  {7'd0, carry_w[mon_e.id]},  {7'd0, mon_e.c});
      check_field(mon_e.nm, "borrow", {7'd0, borrow_w[mon_e.id]}, {7'd0, mon_e.b});
      check_field(mon_e.nm, "at_max", {7'd0, at_max_w[mon_e.id]}, {7'd0, mon_e.am});
      check_field(mon_e.nm, "err",    {7'd0, err_w[mon_e.id]},    {7'd0, mon_e.er});
    end
  end

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic drive(input logic [3:0] act, input logic [7:0] ld_v, input logic [7:0] dm);
    load_i      = act[3];
    en_i        = act[2];
    up_i        = act[1];
    down_i      = act[0];
    load_ten_i  = ld_v[7:4];
    load_unit_i = ld_v[3:0];
    dyn_max_i   = dm;
  endtask

  // flg = {carry, borrow, at_max, err} expected during this cycle, ev = value during this cycle
  task automatic step(input int id, input logic [3:0] act, input logic [7:0] ld_v, input logic [7:0] dm,
                      input logic [7:0] ev, input logic [3:0] flg, input string nm);
    @(posedge clk);
    #1;
    drive(act, ld_v, dm);
    q.push_back('{id, ev, flg[3], flg[2], flg[1], flg[0], nm});
  endtask

  task automatic do_reset(input int id, input logic [7:0] ev, input logic [7:0] dm);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(NONE, 8'h00, dm);
    q.push_back('{id, ev, 1'b0, 1'b0, 1'b0, 1'b0, "reset"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Default range 00..59: full sweep with a single carry at 59
    do_reset(0, 8'h00, 8'h00);
    for (int i = 0; i <= 60; i++) begin
      step(0, EN, 8'h00, 8'h00, to_bcd(i % 60), {i % 60 == 59, 1'b0, i % 60 == 59, 1'b0}, "sweep60");
    end
    for (int k = 1; k <= 46; k++) begin
      step(0, EN, 8'h00, 8'h00, to_bcd(k), 4'b0000, "run_to_47");
    end
    step(0, NONE, 8'h00, 8'h00, 8'h47, 4'b0000, "hold47");
    // Asynchronous reset mid-count, then the first tick after release
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(NONE, 8'h00, 8'h00);
    q.push_back('{0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "rst_async"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(EN, 8'h00, 8'h00);
    q.push_back('{0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "rst_release"});
    step(0, NONE, 8'h00, 8'h00, 8'h01, 4'b0000, "tick_after_rst");

    // Loads on the default range: load with tick at max, bad digit, good load, down adjust
    do_reset(0, 8'h00, 8'h00);
    step(0, LD,      8'h59, 8'h00, 8'h00, 4'b0000, "load59");
    step(0, NONE,    8'h00, 8'h00, 8'h59, 4'b0010, "at59");
    step(0, LD | EN, 8'h42, 8'h00, 8'h59, 4'b0010, "load_en_no_carry");
    step(0, NONE,    8'h00, 8'h00, 8'h42, 4'b0000, "loaded42");
    step(0, LD,      8'h3A, 8'h00, 8'h42, 4'b0000, "load_digit_A");
    step(0, NONE,    8'h00, 8'h00, 8'h42, 4'b0001, "err_digit_A");
    step(0, LD,      8'h37, 8'h00, 8'h42, 4'b0000, "load37");
    step(0, DN,      8'h00, 8'h00, 8'h37, 4'b0000, "loaded37");
    step(0, NONE,    8'h00, 8'h00, 8'h36, 4'b0000, "down36");

    // Run-time bound 28 with MIN_VAL=1
    do_reset(1, 8'h01, 8'h28);
    for (int i = 0; i <= 28; i++) begin
      step(1, EN, 8'h00, 8'h28, to_bcd(1 + i % 28), {i == 27, 1'b0, i == 27, 1'b0}, "dyn28");
    end
    step(1, LD,   8'h31, 8'h28, 8'h02, 4'b0000, "load31");
    step(1, NONE, 8'h00, 8'h28, 8'h02, 4'b0001, "err31");
    step(1, LD,   8'h00, 8'h28, 8'h02, 4'b0000, "load_below_min");
    step(1, NONE, 8'h00, 8'h28, 8'h02, 4'b0001, "err_below_min");
    step(1, LD,   8'h30, 8'h31, 8'h02, 4'b0000, "load30_max31");
    step(1, NONE, 8'h00, 8'h31, 8'h30, 4'b0000, "at30");
    step(1, NONE, 8'h00, 8'h28, 8'h30, 4'b0000, "shrink_to_28");
    step(1, EN,   8'h00, 8'h28, 8'h30, 4'b1010, "over_max_tick");
    step(1, LD,   8'h45, 8'h00, 8'h01, 4'b0000, "bad_dyn_fallback");
    step(1, NONE, 8'h00, 8'h00, 8'h45, 4'b0000, "loaded45");

    // Adjust wraps with ADJ_CARRY=1, range 00..23
    do_reset(2, 8'h00, 8'h00);
    step(2, DN,      8'h00, 8'h00, 8'h00, 4'b0100, "down_wrap_borrow");
    step(2, UP,      8'h00, 8'h00, 8'h23, 4'b1010, "up_wrap_carry");
    step(2, LD,      8'h10, 8'h00, 8'h00, 4'b0000, "after_up_wrap");
    step(2, DN,      8'h00, 8'h00, 8'h10, 4'b0000, "loaded10");
    step(2, LD,      8'h05, 8'h00, 8'h09, 4'b0000, "down_to_09");
    step(2, EN | UP, 8'h00, 8'h00, 8'h05, 4'b0000, "en_up_at05");
    step(2, UP | DN, 8'h00, 8'h00, 8'h06, 4'b0000, "single_inc06");
    step(2, NONE,    8'h00, 8'h00, 8'h06, 4'b0000, "up_dn_hold");

    // Same adjust wraps with ADJ_CARRY=0: values match, no pulses
    do_reset(3, 8'h00, 8'h00);
    step(3, DN,   8'h00, 8'h00, 8'h00, 4'b0000, "down_wrap_quiet");
    step(3, UP,   8'h00, 8'h00, 8'h23, 4'b0010, "up_wrap_quiet");
    step(3, NONE, 8'h00, 8'h00, 8'h00, 4'b0000, "after_quiet_wrap");

    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_range_counter.md
# bcd_range_counter

Parametrised two-digit BCD counter for the century clock. It counts over a configurable inclusive range [MIN_VAL, MAX_VAL], or up to a run-time upper bound. It supports tick-driven counting, up/down manual adjust, synchronous parallel load, and zero-latency carry/borrow for cascading. One instance serves each field: seconds, minutes, hours, day-of-month, month, and year-of-century.

## Interface
- MIN_VAL, 0: lowest legal value, decimal 0..98; reset value.
- MAX_VAL, 59: highest legal value, decimal MIN_VAL+1..99; static upper bound.
- USE_DYN_MAX, 0: 1 = upper bound taken from dyn_max_i instead of MAX_VAL.
- ADJ_CARRY, 0: 1 = up/down adjust wraps also raise carry_o/borrow_o.
- DIGIT_W, 4: width of each BCD digit port, at least 4.
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_i  in  1  count tick: increment once per cycle high.
- up_i  in  1  manual increment; effective only when en_i=0 and load_i=0.
- down_i  in  1  manual decrement; effective only when en_i=0 and load_i=0.
- load_i  in  1  synchronous load of load_ten_i/load_unit_i.
- load_ten_i  in  DIGIT_W  BCD tens digit to load.
- load_unit_i  in  DIGIT_W  BCD units digit to load.
- dyn_max_i  in  2*DIGIT_W  BCD {ten,unit} upper bound; used only if USE_DYN_MAX=1.
- ten_o  out  DIGIT_W  BCD tens digit, registered.
- unit_o  out  DIGIT_W  BCD units digit, registered.
- carry_o  out  1  wrap-up pulse; next stage's en_i.
- borrow_o  out  1  wrap-down pulse (adjust only).
- at_max_o  out  1  registered flag: current value >= effective max.
- err_o  out  1  one-cycle pulse: load value rejected.

## Operation
- Effective max (EMAX): MAX_VAL, or dyn_max_i when USE_DYN_MAX=1. When USE_DYN_MAX=1, dyn_max_i < MIN_VAL+1 or dyn_max_i > 99 is treated as MAX_VAL.
- Value V = 10*ten_o + unit_o. Digits are always valid BCD (0..9). V is always in [MIN_VAL, 99].
- Action priority per cycle: load_i > en_i > (up_i xor down_i) > hold.
- Load:
  - Accepted if both digits <= 9 and MIN_VAL <= value <= EMAX. V takes the loaded value.
  - Otherwise V is unchanged and err_o=1 for that cycle.
  - carry_o and borrow_o are 0 during a load cycle.
- Count (en_i=1, load_i=0):
  - If V >= EMAX: V <= MIN_VAL.
  - Else if unit=9: unit <= 0, ten <= ten+1.
  - Else: unit <= unit+1.
- Up adjust (up_i=1, down_i=0): same arithmetic as count.
- Down adjust (down_i=1, up_i=0):
  - If V <= MIN_VAL: V <= EMAX.
  - Else if unit=0: unit <= 9, ten <= ten-1.
  - Else: unit <= unit-1.
- up_i=down_i=1, or both 0: hold.
- carry_o = at_max_o & (en_i | (ADJ_CARRY & up_i & ~down_i)) & ~load_i. It is combinational from the registered at_max_o plus inputs.
- borrow_o = ADJ_CARRY & (V == MIN_VAL) & down_i & ~up_i & ~en_i & ~load_i.
- Shrinking EMAX: if dyn_max_i drops below V (e.g. day 31, month changes to 30), V is held. at_max_o goes 1. The next tick wraps V to MIN_VAL with carry_o=1. No silent clamp.

## Timing
- Reset state:
  - ten_o/unit_o = BCD of MIN_VAL.
  - at_max_o = (MIN_VAL >= EMAX) evaluated post-reset, normally 0.
  - carry_o=borrow_o=err_o=0.
- Value latency: 1 cycle. Action sampled at edge N; ten_o/unit_o/at_max_o are valid after edge N.
- carry_o and borrow_o have zero latency: high in the same cycle as the en_i/adjust that causes the wrap. A cascaded stage therefore advances on the same edge. A chain of k stages wraps fully in one cycle.
- at_max_o is registered and recomputed each edge from the next V and the current EMAX. A dyn_max_i change is reflected in at_max_o one edge later.
- err_o is registered: high for the one cycle after the rejecting load edge.
- Reset assertion mid-count forces the reset state immediately, regardless of clk. Counting resumes on the first edge after rst_n deasserts.
- en_i held high continuously: V increments every cycle. carry_o is high exactly one cycle per wrap.

## Test plan
- Default params: reset, en_i=1 for 60 cycles -> 00,01,…,59,00. carry_o=1 only in the cycle V=59. at_max_o=1 only while V=59.
- MIN_VAL=1, USE_DYN_MAX=1, dyn_max_i=0x28:
  - Ticks from 01 -> 28 -> 01, with carry at 28.
  - Load 31 -> err_o=1, V unchanged.
  - At V=30 with dyn_max_i=0x31, switch dyn_max_i to 0x28 -> hold 30, at_max_o=1; next tick -> 01 with carry_o=1.
- ADJ_CARRY=1, MIN_VAL=0, MAX_VAL=23, V=00, down_i=1 -> V=23, borrow_o=1 that cycle. up_i at 23 -> 00, carry_o=1. Repeat with ADJ_CARRY=0 -> same values, carry_o/borrow_o stay 0.
- Simultaneous events:
  - en_i=up_i=1 at V=05 -> 06 (single increment).
  - up_i=down_i=1 -> hold.
  - load_i=1 with en_i=1, load 42 -> 42, carry_o=0 even if at_max_o=1.
- Load digit 0xA -> err_o=1 one cycle, V unchanged. Load 0x3/0x7 -> V=37.
- Reset mid-count at V=47 (MIN_VAL=0) -> outputs 00 asynchronously. The first tick after release -> 01.
